// File: rtl/kianv_bus_pkg.sv
// kianv_bus_pkg: shared widths, router FSM states and KianV SoC address map constants.
package kianv_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int FCNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [ADDR_W-1:0] BRAM_BASE     = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] CLINT_BASE    = 32'h0200_0000;
    localparam logic [ADDR_W-1:0] UART_TX_ADDR  = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] UART_RX_ADDR  = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] UART_LSR_ADDR = 32'h1000_0005;
    localparam logic [ADDR_W-1:0] LED_ADDR      = 32'h1200_0000;
    localparam logic [ADDR_W-1:0] SPI_NOR_BASE  = 32'h2000_0000;
    localparam logic [ADDR_W-1:0] SDRAM_BASE    = 32'h8000_0000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kianv_addr_match.sv
// kianv_addr_match: combinational base/mask decode, lowest index wins, with read-only check.
module kianv_addr_match
    import kianv_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 8,
    parameter int                       SEL_W      = 3,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = '0,
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = '0,
    parameter logic [NUM_SLAVES-1:0]    SLV_RO     = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic              hit_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              ro_violation_o
);

    logic ro;

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        ro    = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(i);
                ro    = SLV_RO[i];
            end
        end
        ro_violation_o = hit_o && ro && |wstrb_i;
    end

endmodule

// File: rtl/kianv_mmio_router.sv
// kianv_mmio_router: registered valid/ready router from the KianV core to N MMIO slaves with timeout and fault capture.
module kianv_mmio_router
    import kianv_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = '0,
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = '0,
    parameter logic [NUM_SLAVES-1:0]    SLV_RO         = '0,
    parameter int                       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]        FAULT_RDATA    = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         cpu_valid_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [STRB_W-1:0]            cpu_wstrb_i,
    input  logic [DATA_W-1:0]            cpu_wdata_i,
    output logic                         cpu_ready_o,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    output logic                         cpu_fault_o,
    output logic [NUM_SLAVES-1:0]        slv_valid_o,
    output logic [ADDR_W-1:0]            slv_addr_o,
    output logic [STRB_W-1:0]            slv_wstrb_o,
    output logic [DATA_W-1:0]            slv_wdata_o,
    input  logic [NUM_SLAVES-1:0]        slv_ready_i,
    input  logic [DATA_W*NUM_SLAVES-1:0] slv_rdata_i,
    output logic [ADDR_W-1:0]            fault_addr_o,
    output logic [FCNT_W-1:0]            fault_count_o
);

    localparam int SEL_W = idx_width(NUM_SLAVES);
    localparam int TMO_W = idx_width(TIMEOUT_CYCLES + 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_SLAVES-1:0] slv_valid_q, slv_valid_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [ADDR_W-1:0]     fault_addr_q, fault_addr_d;
    logic [FCNT_W-1:0]     fault_count_q, fault_count_d;
    logic                  hit, ro_viol, log_fault;
    logic [SEL_W-1:0]      sel;

    kianv_addr_match #(
        .NUM_SLAVES(NUM_SLAVES),
        .SEL_W     (SEL_W),
        .SLV_BASE  (SLV_BASE),
        .SLV_MASK  (SLV_MASK),
        .SLV_RO    (SLV_RO)
    ) u_match (
        .addr_i        (cpu_addr_i),
        .wstrb_i       (cpu_wstrb_i),
        .hit_o         (hit),
        .sel_o         (sel),
        .ro_violation_o(ro_viol)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        slv_valid_d = slv_valid_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        log_fault   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid_i) begin
                    addr_d  = cpu_addr_i;
                    wstrb_d = cpu_wstrb_i;
                    wdata_d = cpu_wdata_i;
                    if (hit && !ro_viol) begin
                        sel_d       = sel;
                        slv_valid_d = NUM_SLAVES'(1) << sel;
                        tmo_d       = '0;
                        state_d     = ST_BUSY;
                    end else begin
                        fault_d   = 1'b1;
                        log_fault = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                // Ready is checked first so a same-cycle timeout never faults a completed access.
                if (slv_ready_i[sel_q]) begin
                    rdata_d     = slv_rdata_i[32*sel_q +: 32];
                    fault_d     = 1'b0;
                    slv_valid_d = '0;
                    state_d     = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    fault_d     = 1'b1;
                    log_fault   = 1'b1;
                    slv_valid_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fault_addr_d  = log_fault ? addr_d : fault_addr_q;
        fault_count_d = (log_fault && fault_count_q != '1) ? fault_count_q + 1'b1 : fault_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wstrb_q       <= '0;
            wdata_q       <= '0;
            sel_q         <= '0;
            slv_valid_q   <= '0;
            tmo_q         <= '0;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wstrb_q       <= wstrb_d;
            wdata_q       <= wdata_d;
            sel_q         <= sel_d;
            slv_valid_q   <= slv_valid_d;
            tmo_q         <= tmo_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign cpu_ready_o   = state_q == ST_RESP;
    assign cpu_fault_o   = cpu_ready_o && fault_q;
    assign cpu_rdata_o   = !cpu_ready_o ? '0 : fault_q ? FAULT_RDATA : rdata_q;
    assign slv_valid_o   = slv_valid_q;
    assign slv_addr_o    = addr_q;
    assign slv_wstrb_o   = wstrb_q;
    assign slv_wdata_o   = wdata_q;
    assign fault_addr_o  = fault_addr_q;
    assign fault_count_o = fault_count_q;

endmodule

// File: tb/tb_kianv_mmio_router.sv
// tb_kianv_mmio_router: directed vectors against a hand-built 8-slave map with a 16-cycle timeout.
module tb_kianv_mmio_router;
    import kianv_bus_pkg::*;

    localparam int N = 8;
    localparam logic [31:0] FRD = 32'hDEAD_BEEF;
    localparam logic [32*N-1:0] BASE = {32'h0000_0000, 32'h0200_0000, 32'h8000_0000, 32'h2000_0000,
                                        32'h4000_0000, 32'h1000_0000, 32'h1200_0000, 32'h4000_0000};
    localparam logic [32*N-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000,
                                        32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000};
    localparam logic [N-1:0] RO = 8'b0000_0010;

    logic          clk = 1'b0;
    logic          resetn, cpu_valid, cpu_ready, cpu_fault;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata, slv_addr, slv_wdata, fault_addr;
    logic [3:0]    cpu_wstrb, slv_wstrb;
    logic [N-1:0]  slv_valid, slv_ready;
    logic [32*N-1:0] slv_rdata;
    logic [15:0]   fault_count;
    int            total = 0, bad = 0;
    int            lat, vcnt;
    logic          flt;
    logic [31:0]   rdat, sa;
    logic [7:0]    vseen;

    always #5 clk = ~clk;

    kianv_mmio_router #(
        .NUM_SLAVES(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_RO(RO),
        .TIMEOUT_CYCLES(16), .FAULT_RDATA(FRD)
    ) dut (
        .clk_i(clk), .resetn_i(resetn),
        .cpu_valid_i(cpu_valid), .cpu_addr_i(cpu_addr), .cpu_wstrb_i(cpu_wstrb), .cpu_wdata_i(cpu_wdata),
        .cpu_ready_o(cpu_ready), .cpu_rdata_o(cpu_rdata), .cpu_fault_o(cpu_fault),
        .slv_valid_o(slv_valid), .slv_addr_o(slv_addr), .slv_wstrb_o(slv_wstrb), .slv_wdata_o(slv_wdata),
        .slv_ready_i(slv_ready), .slv_rdata_i(slv_rdata),
        .fault_addr_o(fault_addr), .fault_count_o(fault_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave rs raises ready in its rdly-th valid cycle (rs < 0: never); stray bits pulse while any slave is busy.
    task automatic run(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd, input int rs,
                       input int rdly, input logic [31:0] rd, input logic [7:0] stray,
                       output int lt, output logic f, output logic [31:0] r, output int vc,
                       output logic [7:0] vs, output logic [31:0] s);
        bit got = 0;
        cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = ws; cpu_wdata = wd;
        lt = 0; f = 1'b0; r = '0; vc = 0; vs = '0; s = '0;
        for (int c = 1; c <= 64 && !got; c++) begin
            @(negedge clk);
            slv_ready = '0;
            if (cpu_ready) begin
                got = 1; lt = c; f = cpu_fault; r = cpu_rdata; cpu_valid = 1'b0;
            end else if (|slv_valid) begin
                vc++;
                vs |= slv_valid;
                if (vc == 1) s = slv_addr;
                slv_ready = stray;
                if (rs >= 0 && vc == rdly && slv_valid[rs]) begin
                    slv_ready[rs] = 1'b1;
                    slv_rdata[32*rs +: 32] = rd;
                end
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("single_pulse", 32'(cpu_ready), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0;
        slv_ready = '0; slv_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_valid", 32'(slv_valid), 32'h0);
        chk("rst_fcnt", 32'(fault_count), 32'd0);
        chk("rst_faddr", fault_addr, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        run(32'h1000_0004, 4'h0, 32'h0, 2, 3, 32'hCAFE_0001, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_fault", 32'(flt), 32'd0);
        chk("t1_rdata", rdat, 32'hCAFE_0001);
        chk("t1_vseen", 32'(vseen), 32'h04);
        chk("t1_saddr", sa, 32'h1000_0004);

        run(32'h3000_0000, 4'h0, 32'h0, -1, 0, 32'h0, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t2_lat", 32'(lat), 32'd1);
        chk("t2_fault", 32'(flt), 32'd1);
        chk("t2_rdata", rdat, FRD);
        chk("t2_vseen", 32'(vseen), 32'h00);
        chk("t2_faddr", fault_addr, 32'h3000_0000);
        chk("t2_fcnt", 32'(fault_count), 32'd1);

        run(32'h1200_0000, 4'b0001, 32'h55, 1, 1, 32'h0, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t3w_fault", 32'(flt), 32'd1);
        chk("t3w_vseen", 32'(vseen), 32'h00);
        chk("t3w_fcnt", 32'(fault_count), 32'd2);
        chk("t3w_faddr", fault_addr, 32'h1200_0000);
        run(32'h1200_0000, 4'b0000, 32'h0, 1, 1, 32'h0000_00A5, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t3r_fault", 32'(flt), 32'd0);
        chk("t3r_rdata", rdat, 32'h0000_00A5);
        chk("t3r_vseen", 32'(vseen), 32'h02);
        chk("t3r_lat", 32'(lat), 32'd2);

        run(32'h2000_0100, 4'hF, 32'hA5A5_5A5A, 4, 1, 32'h0, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("wr_fault", 32'(flt), 32'd0);
        chk("wr_vseen", 32'(vseen), 32'h10);
        chk("wr_wdata", slv_wdata, 32'hA5A5_5A5A);
        chk("wr_wstrb", 32'(slv_wstrb), 32'hF);

        run(32'h8000_0010, 4'h0, 32'h0, -1, 0, 32'h0, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t4a_vcnt", 32'(vcnt), 32'd16);
        chk("t4a_fault", 32'(flt), 32'd1);
        chk("t4a_rdata", rdat, FRD);
        chk("t4a_lat", 32'(lat), 32'd17);
        chk("t4a_fcnt", 32'(fault_count), 32'd3);
        chk("t4a_faddr", fault_addr, 32'h8000_0010);
        run(32'h8000_0010, 4'h0, 32'h0, 5, 16, 32'h1234_5678, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t4b_vcnt", 32'(vcnt), 32'd16);
        chk("t4b_fault", 32'(flt), 32'd0);
        chk("t4b_rdata", rdat, 32'h1234_5678);
        chk("t4b_fcnt", 32'(fault_count), 32'd3);

        slv_rdata[32*5 +: 32] = 32'hFFFF_0000;
        run(32'h4000_0020, 4'h0, 32'h0, 0, 2, 32'h0000_0F00, 8'h20, lat, flt, rdat, vcnt, vseen, sa);
        chk("t5_vseen", 32'(vseen), 32'h01);
        chk("t5_lat", 32'(lat), 32'd3);
        chk("t5_rdata", rdat, 32'h0000_0F00);
        chk("t5_fault", 32'(flt), 32'd0);

        cpu_valid = 1'b1; cpu_addr = 32'h0200_0000; cpu_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        chk("t6_busy_valid", 32'(slv_valid), 32'h40);
        resetn = 1'b0; cpu_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(slv_valid), 32'h0);
        chk("t6_ready", 32'(cpu_ready), 32'd0);
        chk("t6_saddr", slv_addr, 32'h0);
        chk("t6_fcnt", 32'(fault_count), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_noresp", 32'(cpu_ready), 32'd0);
        run(32'h0000_0040, 4'h0, 32'h0, 7, 1, 32'h0000_7777, 8'h0, lat, flt, rdat, vcnt, vseen, sa);
        chk("t6r_lat", 32'(lat), 32'd2);
        chk("t6r_rdata", rdat, 32'h0000_7777);
        chk("t6r_vseen", 32'(vseen), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
